// File: rtl/uart_chk_pkg.sv
// Shared encodings for the UART receive-path frame checker.
package uart_chk_pkg;

  localparam logic [1:0] CHK_START = 2'd0;
  localparam logic [1:0] CHK_PAR   = 2'd1;
  localparam logic [1:0] CHK_STOP  = 2'd2;
  localparam logic [1:0] CHK_NONE  = 2'd3;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_maj_sampler.sv
// Mid-bit 3-sample majority voter: captures the line at m-1 and m, votes with
// the live line at m+1 and strobes eval_stb for that one cycle.
module uart_maj_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic                  chk_en,
  output logic                  eval_stb,
  output logic                  vote,
  output logic                  split
);

  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] pt_lo;
  logic [PRESCALE_W-1:0] pt_hi;
  logic                  at_lo;
  logic                  at_mid;
  logic                  at_hi;
  logic                  s0;
  logic                  s1;
  logic [1:0]            got;

  assign mid    = prescale >> 1;
  assign pt_lo  = mid - PRESCALE_W'(1);
  assign pt_hi  = mid + PRESCALE_W'(1);
  assign at_lo  = (edge_cnt == pt_lo);
  assign at_mid = (edge_cnt == mid);
  assign at_hi  = (edge_cnt == pt_hi);

  // got[0]: sample at m-1 held, got[1]: sample at m held on top of it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0  <= 1'b0;
      s1  <= 1'b0;
      got <= 2'b00;
    end else if (!chk_en || edge_cnt == '0) begin
      got <= 2'b00;
    end else if (at_lo) begin
      s0  <= rx_in;
      got <= 2'b01;
    end else if (at_mid) begin
      s1  <= rx_in;
      got <= {got[0], got[0]};
    end else if (at_hi) begin
      got <= 2'b00;
    end
  end

  assign eval_stb = chk_en && at_hi && (got == 2'b11);
  assign vote     = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);
  assign split    = !((s0 == s1) && (s1 == rx_in));

endmodule

// File: rtl/uart_frame_check.sv
// UART frame checker: start/parity/stop verdicts from one majority-voted
// sample, per-type error and noise flags, and saturating error counters.
module uart_frame_check
  import uart_chk_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         rx_in,
  input  logic [PRESCALE_W-1:0]        prescale,
  input  logic [PRESCALE_W-1:0]        edge_cnt,
  input  logic                         chk_en,
  input  logic [1:0]                   chk_type,
  input  logic                         par_type,
  input  logic [DATA_W-1:0]            data_word,
  input  logic [$clog2(DATA_W+1)-1:0]  data_len,
  input  logic                         clr_cnt,
  output logic                         sampled_bit,
  output logic                         chk_done,
  output logic                         strt_glitch,
  output logic                         par_err,
  output logic                         stop_err,
  output logic                         noise,
  output logic [CNT_W-1:0]             strt_err_cnt,
  output logic [CNT_W-1:0]             par_err_cnt,
  output logic [CNT_W-1:0]             stop_err_cnt
);

  localparam int LEN_W = $clog2(DATA_W+1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic eval_stb;
  logic vote;
  logic split;
  logic par_exp;
  logic strt_hit;
  logic par_hit;
  logic stop_hit;

  uart_maj_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .rx_in    (rx_in),
    .prescale (prescale),
    .edge_cnt (edge_cnt),
    .chk_en   (chk_en),
    .eval_stb (eval_stb),
    .vote     (vote),
    .split    (split)
  );

  // Expected parity bit over the first data_len received bits.
  function automatic logic calc_par(input logic [DATA_W-1:0] w,
                                    input logic [LEN_W-1:0]  len,
                                    input logic              pt);
    logic p;
    p = pt;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(len)) p = p ^ w[i];
    end
    return p;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  assign par_exp  = calc_par(data_word, data_len, par_type);
  assign strt_hit = eval_stb && (chk_type == CHK_START) && vote;
  assign par_hit  = eval_stb && (chk_type == CHK_PAR) && (vote != par_exp);
  assign stop_hit = eval_stb && (chk_type == CHK_STOP) && !vote;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sampled_bit <= 1'b0;
      chk_done    <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stop_err    <= 1'b0;
      noise       <= 1'b0;
    end else begin
      chk_done <= eval_stb;
      if (!chk_en) begin
        strt_glitch <= 1'b0;
        par_err     <= 1'b0;
        stop_err    <= 1'b0;
        noise       <= 1'b0;
      end else if (eval_stb) begin
        sampled_bit <= vote;
        noise       <= split;
        case (chk_type)
          CHK_START: strt_glitch <= vote;
          CHK_PAR:   par_err     <= (vote != par_exp);
          CHK_STOP:  stop_err    <= !vote;
          default:   ;
        endcase
      end
    end
  end

  // A clear in the same cycle as an error wins over the increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      strt_err_cnt <= '0;
      par_err_cnt  <= '0;
      stop_err_cnt <= '0;
    end else if (clr_cnt) begin
      strt_err_cnt <= '0;
      par_err_cnt  <= '0;
      stop_err_cnt <= '0;
    end else begin
      if (strt_hit) strt_err_cnt <= sat_inc(strt_err_cnt);
      if (par_hit)  par_err_cnt  <= sat_inc(par_err_cnt);
      if (stop_hit) stop_err_cnt <= sat_inc(stop_err_cnt);
    end
  end

endmodule

// File: tb/tb_uart_frame_check.sv
// Bench for uart_frame_check: directed scenarios then randomized bits, checked
// cycle by cycle against a bit-level reference model.
module tb_uart_frame_check;
  import uart_chk_pkg::*;

  localparam int PW   = 6;
  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int LW   = $clog2(DW+1);
  localparam int W    = 12;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK;
  logic          RST;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic [PW-1:0] edge_cnt;
  logic          chk_en;
  logic [1:0]    chk_type;
  logic          par_type;
  logic [DW-1:0] data_word;
  logic [LW-1:0] data_len;
  logic          clr_cnt;
  logic          sampled_bit;
  logic          chk_done;
  logic          strt_glitch;
  logic          par_err;
  logic          stop_err;
  logic          noise;
  logic [CW-1:0] strt_err_cnt;
  logic [CW-1:0] par_err_cnt;
  logic [CW-1:0] stop_err_cnt;

  uart_frame_check #(.PRESCALE_W(PW), .DATA_W(DW), .CNT_W(CW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .edge_cnt     (edge_cnt),
    .chk_en       (chk_en),
    .chk_type     (chk_type),
    .par_type     (par_type),
    .data_word    (data_word),
    .data_len     (data_len),
    .clr_cnt      (clr_cnt),
    .sampled_bit  (sampled_bit),
    .chk_done     (chk_done),
    .strt_glitch  (strt_glitch),
    .par_err      (par_err),
    .stop_err     (stop_err),
    .noise        (noise),
    .strt_err_cnt (strt_err_cnt),
    .par_err_cnt  (par_err_cnt),
    .stop_err_cnt (stop_err_cnt)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model state
  int   total = 0;
  int   bad   = 0;
  logic m_sb, m_done, m_sg, m_pe, m_se, m_nz;
  int   m_cs, m_cp, m_cst;
  int   cur_m;
  logic cur_ev, cur_vote, cur_split;
  logic [W-1:0] exp_q[$];
  int   sat_exp[5] = '{1, 2, 3, 3, 3};

  function automatic logic [W-1:0] dut_vec();
    return {sampled_bit, chk_done, strt_glitch, par_err, stop_err, noise,
            strt_err_cnt, par_err_cnt, stop_err_cnt};
  endfunction

  function automatic logic [W-1:0] model_vec();
    return {m_sb, m_done, m_sg, m_pe, m_se, m_nz,
            CW'(m_cs), CW'(m_cp), CW'(m_cst)};
  endfunction

  function automatic void model_reset();
    m_sb = 0; m_done = 0; m_sg = 0; m_pe = 0; m_se = 0; m_nz = 0;
    m_cs = 0; m_cp = 0; m_cst = 0;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  // One clock of one bit: update the model for this edge, then compare.
  task automatic step(input int e, input logic rx, input logic en, input logic clr);
    int   ones;
    logic pexp;
    edge_cnt = PW'(e);
    rx_in    = rx;
    chk_en   = en;
    clr_cnt  = clr;
    m_done   = 0;
    if (!en) begin
      m_sg = 0; m_pe = 0; m_se = 0; m_nz = 0;
    end else if (e == cur_m + 1 && cur_ev) begin
      m_done = 1;
      m_sb   = cur_vote;
      m_nz   = cur_split;
      case (chk_type)
        CHK_START: begin
          m_sg = (cur_vote != 0);
          if (m_sg && m_cs < CMAX) m_cs++;
        end
        CHK_PAR: begin
          ones = $countones(data_word & DW'((1 << data_len) - 1));
          pexp = ((ones % 2) == 1) ^ par_type;
          m_pe = (cur_vote != pexp);
          if (m_pe && m_cp < CMAX) m_cp++;
        end
        CHK_STOP: begin
          m_se = (cur_vote != 1);
          if (m_se && m_cst < CMAX) m_cst++;
        end
        default: ;
      endcase
    end
    if (clr) begin
      m_cs = 0; m_cp = 0; m_cst = 0;
    end
    exp_q.push_back(model_vec());
    @(posedge CLK);
    #1;
    chk($sformatf("cyc_e%0d_t%0d", e, chk_type), dut_vec(), exp_q.pop_front());
  endtask

  // Drive one whole bit; smp[0..2] is the line at m-1, m, m+1.
  task automatic run_bit(input int ps, input logic [1:0] ct, input logic [2:0] smp,
                         input int drop_e, input int clr_e);
    logic rx;
    prescale  = PW'(ps);
    chk_type  = ct;
    cur_m     = ps / 2;
    cur_ev    = !(drop_e >= cur_m - 1 && drop_e <= cur_m + 1);
    cur_vote  = ($countones(smp) >= 2);
    cur_split = (smp != 3'b000 && smp != 3'b111);
    for (int e = 0; e < ps; e++) begin
      if (e == cur_m - 1)      rx = smp[0];
      else if (e == cur_m)     rx = smp[1];
      else if (e == cur_m + 1) rx = smp[2];
      else                     rx = 1'($urandom_range(0, 1));
      step(e, rx, e != drop_e, e == clr_e);
    end
  endtask

  initial begin
    int ps, dr, cl;
    RST = 1'b0; rx_in = 1'b1; prescale = PW'(8); edge_cnt = '0; chk_en = 1'b0;
    chk_type = CHK_NONE; par_type = PAR_EVEN; data_word = '0; data_len = LW'(8);
    clr_cnt = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_state", dut_vec(), '0);
    RST = 1'b1;

    // Start pass
    run_bit(8, CHK_START, 3'b000, -1, -1);
    chk("strt_pass_flag", W'(strt_glitch), '0);
    chk("strt_pass_cnt", W'(strt_err_cnt), '0);

    // Start glitch (0,1,1), chk_en dropped the cycle after evaluation
    run_bit(8, CHK_START, 3'b110, 6, -1);
    chk("glitch_cnt", W'(strt_err_cnt), W'(1));
    chk("glitch_cleared", W'(strt_glitch), '0);

    // Parity on 8'hA5
    data_word = 8'hA5;
    data_len = LW'(8); par_type = PAR_EVEN;
    run_bit(8, CHK_PAR, 3'b111, -1, -1);
    chk("par_even8", W'(par_err), W'(1));
    par_type = PAR_ODD;
    run_bit(8, CHK_PAR, 3'b111, -1, -1);
    chk("par_odd8", W'(par_err), W'(0));
    data_len = LW'(7); par_type = PAR_EVEN;
    run_bit(8, CHK_PAR, 3'b111, -1, -1);
    chk("par_even7", W'(par_err), W'(0));

    // Stop counter saturation, then clear racing a sixth error
    for (int i = 0; i < 5; i++) begin
      run_bit(8, CHK_STOP, 3'b000, -1, -1);
      chk("stop_sat", W'(stop_err_cnt), W'(sat_exp[i]));
    end
    run_bit(8, CHK_STOP, 3'b000, -1, 5);
    chk("stop_clr_cnt", W'(stop_err_cnt), '0);
    chk("stop_clr_flag", W'(stop_err), W'(1));

    // Abort mid-sampling, then a clean 16x bit
    run_bit(8, CHK_START, 3'b111, 4, -1);
    chk("abort_flag", W'(strt_glitch), '0);
    run_bit(16, CHK_START, 3'b000, -1, -1);
    chk("after_abort_sb", W'(sampled_bit), '0);

    // Asynchronous reset with errors pending and samples half-taken
    run_bit(8, CHK_START, 3'b111, -1, -1);
    prescale = PW'(8); chk_type = CHK_START;
    cur_m = 4; cur_ev = 1'b1; cur_vote = 1'b1; cur_split = 1'b0;
    for (int e = 0; e <= 4; e++) step(e, 1'b1, 1'b1, 1'b0);
    #1 RST = 1'b0;
    #1;
    model_reset();
    chk("rst_async", dut_vec(), model_vec());
    RST = 1'b1;
    cur_ev = 1'b0;
    for (int e = 5; e < 8; e++) step(e, 1'b1, 1'b1, 1'b0);
    run_bit(8, CHK_START, 3'b000, -1, -1);
    chk("rst_clean_flag", W'(strt_glitch), '0);
    chk("rst_clean_cnt", W'(strt_err_cnt), '0);

    // Randomized bits
    for (int n = 0; n < 40; n++) begin
      ps = int'($urandom_range(MIN_PRESCALE, 20));
      dr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ps - 1)) : -1;
      cl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, ps - 1)) : -1;
      data_word = DW'($urandom);
      data_len  = LW'($urandom_range(5, DW));
      par_type  = 1'($urandom_range(0, 1));
      run_bit(ps, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), dr, cl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
